// File: rtl/vga_sync.sv
// vga_sync: VGA raster counters with registered blanking/strobes and a
// programmable delay pipe on hsync/vsync to match downstream color latency.
module vga_sync #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   SYNC_DELAY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x_val,
    output logic [9:0] y_val,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       vblank_start
);
    localparam int          H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int          PW      = SYNC_DELAY + 1;
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic          h_wrap;
    logic [9:0]    x_nxt;
    logic [9:0]    y_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic [PW-1:0] hs_pipe;
    logic [PW-1:0] vs_pipe;

    // Everything registered below is derived from the next counter values so
    // it lands on the same edge as the counters themselves.
    always_comb begin
        h_wrap = x_val == H_LAST;
        x_nxt  = h_wrap ? 10'd0 : x_val + 10'd1;
        y_nxt  = !h_wrap ? y_val : (y_val == V_LAST ? 10'd0 : y_val + 10'd1);
        hs_nxt = ({1'b0, x_nxt} >= HS_BEG && {1'b0, x_nxt} < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_nxt = ({1'b0, y_nxt} >= VS_BEG && {1'b0, y_nxt} < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_val        <= H_LAST;
            y_val        <= V_LAST;
            video_on     <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            hs_pipe      <= {PW{~SYNC_ACTIVE}};
            vs_pipe      <= {PW{~SYNC_ACTIVE}};
        end else begin
            x_val        <= x_nxt;
            y_val        <= y_nxt;
            video_on     <= {1'b0, x_nxt} < H_VIS && {1'b0, y_nxt} < V_VIS;
            frame_start  <= x_nxt == 10'd0 && y_nxt == 10'd0;
            vblank_start <= x_nxt == 10'd0 && {1'b0, y_nxt} == V_VIS;
            // Stage 0 holds the undelayed sync; the cast drops the oldest stage.
            hs_pipe      <= PW'({hs_pipe, hs_nxt});
            vs_pipe      <= PW'({vs_pipe, vs_nxt});
        end
    end

    assign hsync = hs_pipe[SYNC_DELAY];
    assign vsync = vs_pipe[SYNC_DELAY];
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed vector table plus hand sequences for frame strobes,
// delayed sync and mid-frame reset on default and reduced raster geometries.
module tb_vga_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] x0, y0, x3, y3, xp, yp, xs, ys;
    logic hs0, vs0, von0, fs0, vb0;
    logic hs3, vs3, von3, fs3, vb3;
    logic hsp, vsp, vonp, fsp, vbp;
    logic hss, vss, vons, fss, vbs;

    vga_sync #(.SYNC_DELAY(0)) d0 (
        .clk(clk), .rst(rst), .x_val(x0), .y_val(y0), .hsync(hs0), .vsync(vs0),
        .video_on(von0), .frame_start(fs0), .vblank_start(vb0));
    vga_sync #(.SYNC_DELAY(3)) d3 (
        .clk(clk), .rst(rst), .x_val(x3), .y_val(y3), .hsync(hs3), .vsync(vs3),
        .video_on(von3), .frame_start(fs3), .vblank_start(vb3));
    vga_sync #(.SYNC_ACTIVE(1'b1), .SYNC_DELAY(0)) dp (
        .clk(clk), .rst(rst), .x_val(xp), .y_val(yp), .hsync(hsp), .vsync(vsp),
        .video_on(vonp), .frame_start(fsp), .vblank_start(vbp));
    // Reduced geometry: 15 clocks/line, 10 lines/frame, 150 clocks/frame.
    vga_sync #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
               .SYNC_DELAY(3)) ds (
        .clk(clk), .rst(rst), .x_val(xs), .y_val(ys), .hsync(hss), .vsync(vss),
        .video_on(vons), .frame_start(fss), .vblank_start(vbs));

    typedef struct {
        int k;
        logic [9:0] x, y;
        logic von, fs, vb, h0, h3, hp, v0;
    } vec_t;

    vec_t vecs[16];
    int checks = 0;
    int errors = 0;
    int k = -1;
    int fs_q[$];
    int vb_q[$];
    int vs_low = 0, first_vs = -1, von_s = 0, hs_low = 0, von_line = 0;
    int hs_pre = 0, vs_pre = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    function automatic logic exp_hs3(input int kk);
        int m;
        m = kk - 3;
        return (m >= 0 && m % 800 >= 656 && m % 800 < 752) ? 1'b0 : 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        k++;
        if (k < 320) begin
            if (fss) fs_q.push_back(k);
            if (vbs) vb_q.push_back(k);
        end
        if (k < 150) begin
            if (!vss) begin
                vs_low++;
                if (first_vs < 0) first_vs = k;
            end
            if (vons) von_s++;
        end
        if (k < 800) begin
            if (!hs0) hs_low++;
            if (von0) von_line++;
        end
        chk("hs3_shift", hs3, exp_hs3(k));
    endtask

    initial begin
        //           k     x    y   von fs vb h0 h3 hp v0
        vecs[0]  = '{0,    0,   0,  1, 1, 0, 1, 1, 0, 1};
        vecs[1]  = '{1,    1,   0,  1, 0, 0, 1, 1, 0, 1};
        vecs[2]  = '{639,  639, 0,  1, 0, 0, 1, 1, 0, 1};
        vecs[3]  = '{640,  640, 0,  0, 0, 0, 1, 1, 0, 1};
        vecs[4]  = '{655,  655, 0,  0, 0, 0, 1, 1, 0, 1};
        vecs[5]  = '{656,  656, 0,  0, 0, 0, 0, 1, 1, 1};
        vecs[6]  = '{658,  658, 0,  0, 0, 0, 0, 1, 1, 1};
        vecs[7]  = '{659,  659, 0,  0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{751,  751, 0,  0, 0, 0, 0, 0, 1, 1};
        vecs[9]  = '{752,  752, 0,  0, 0, 0, 1, 0, 0, 1};
        vecs[10] = '{754,  754, 0,  0, 0, 0, 1, 0, 0, 1};
        vecs[11] = '{755,  755, 0,  0, 0, 0, 1, 1, 0, 1};
        vecs[12] = '{799,  799, 0,  0, 0, 0, 1, 1, 0, 1};
        vecs[13] = '{800,  0,   1,  1, 0, 0, 1, 1, 0, 1};
        vecs[14] = '{1456, 656, 1,  0, 0, 0, 0, 1, 1, 1};
        vecs[15] = '{1459, 659, 1,  0, 0, 0, 0, 0, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", x0, 799);
        chk("rst_y", y0, 524);
        chk("rst_hs", hs0, 1);
        chk("rst_vs", vs0, 1);
        chk("rst_von", von0, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_vb", vb0, 0);
        chk("rst_hs3", hs3, 1);
        chk("rst_hsp", hsp, 0);
        chk("rst_vsp", vsp, 0);
        chk("rst_xs", xs, 14);
        chk("rst_ys", ys, 9);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            while (k < vecs[i].k) step();
            chk("x", x0, vecs[i].x);
            chk("y", y0, vecs[i].y);
            chk("video_on", von0, vecs[i].von);
            chk("frame_start", fs0, vecs[i].fs);
            chk("vblank_start", vb0, vecs[i].vb);
            chk("hsync_d0", hs0, vecs[i].h0);
            chk("hsync_d3", hs3, vecs[i].h3);
            chk("hsync_pol", hsp, vecs[i].hp);
            chk("vsync_d0", vs0, vecs[i].v0);
        end

        while (k < 1484) step();
        chk("line_hs_low", hs_low, 96);
        chk("line_von", von_line, 640);
        chk("ds_von_frame", von_s, 48);
        chk("ds_vs_low", vs_low, 30);
        chk("ds_vs_first", first_vs, 108);
        chk("ds_fs_count", fs_q.size(), 3);
        chk("ds_vb_count", vb_q.size(), 2);
        for (int i = 0; i < fs_q.size() && i < 3; i++) chk("ds_fs_at", fs_q[i], 150 * i);
        for (int i = 0; i < vb_q.size() && i < 2; i++) chk("ds_vb_at", vb_q[i], 90 + 150 * i);
        if (fs_q.size() >= 2 && vb_q.size() >= 1) chk("ds_vb_lead", fs_q[1] - vb_q[0], 60);

        // Reduced raster is now at (14,8) with both delayed syncs asserted.
        chk("mid_xs", xs, 14);
        chk("mid_ys", ys, 8);
        chk("mid_hss", hss, 0);
        chk("mid_vss", vss, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_xs", xs, 14);
        chk("mrst_ys", ys, 9);
        chk("mrst_hss", hss, 1);
        chk("mrst_vss", vss, 1);
        chk("mrst_vons", vons, 0);
        chk("mrst_x0", x0, 799);
        chk("mrst_y0", y0, 524);
        rst = 1'b0;
        for (int j = 0; j <= 108; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("rel_xs", xs, 0);
                chk("rel_ys", ys, 0);
                chk("rel_fss", fss, 1);
                chk("rel_x0", x0, 0);
                chk("rel_fs0", fs0, 1);
            end
            if (j == 1) chk("rel_fss_drop", fss, 0);
            if (j < 13 && !hss) hs_pre++;
            if (j == 13) chk("rel_hs_first", hss, 0);
            if (j < 108 && !vss) vs_pre++;
            if (j == 108) chk("rel_vs_first", vss, 0);
        end
        chk("rel_hs_quiet", hs_pre, 0);
        chk("rel_vs_quiet", vs_pre, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
